// File: rtl/fir_out_pkg.sv
// fir_out_pkg: shared widths, sample types and the round/shift/saturate helper for the FIR output stage
package fir_out_pkg;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    typedef logic signed [IN_W-1:0]  sample_in_t;
    typedef logic signed [OUT_W-1:0] sample_out_t;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;
    // one guard bit keeps the rounding add from wrapping near full scale
    function automatic sample_out_t round_sat(input sample_in_t in, input int shift);
        logic signed [IN_W:0] ext, rnd;
        ext = {in[IN_W-1], in};
        rnd = (IN_W+1)'(1) << (shift - 1);
        ext = (ext + rnd) >>> shift;
        return ext > (IN_W+1)'(SAT_MAX) ? sample_out_t'(SAT_MAX) :
               ext < (IN_W+1)'(SAT_MIN) ? sample_out_t'(SAT_MIN) : sample_out_t'(ext);
    endfunction
endpackage

// File: rtl/fir_output_decimator_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO
// ports: clk, reset (async, active-high), push/din, pop, dout = head entry, level/full/empty status
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: keeps every DECIM-th filter sample, rounds/saturates to OUT_W, buffers it for a valid/ready sink
// ports: clk, reset (async, active-high); in_valid/in_data from the filter; out_valid/out_ready/out_data to the sink;
//        fifo_level, sticky overflow and saturating drop_count, cleared by clr_overflow
module fir_output_decimator #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [IN_W-1:0]        in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [7:0]                    drop_count
);
    import fir_out_pkg::*;
    localparam int PW = $clog2(DECIM + 1);
    logic [PW-1:0]           phase;
    logic                    keep, stage_valid, full, empty, pop, push, drop;
    logic signed [OUT_W-1:0] stage_data, head, last;
    assign keep      = in_valid && phase == '0;
    assign pop       = !empty && out_ready;
    assign push      = stage_valid && (!full || pop);
    assign drop      = stage_valid && full && !pop;
    assign out_valid = !empty;
    // an empty FIFO keeps presenting the last head rather than stale storage
    assign out_data  = empty ? last : head;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            phase       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            last        <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (in_valid) phase <= phase == PW'(DECIM - 1) ? '0 : phase + 1'b1;
            stage_valid <= keep;
            if (keep) stage_data <= round_sat(in_data, SHIFT);
            if (!empty) last <= head;
            // a drop in the clearing cycle still counts as a fresh first drop
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clr_overflow ? 8'd1 : drop_count + {7'd0, drop_count != 8'hFF};
            end else if (clr_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    sync_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (stage_data),
        .dout (head),
        .level(fifo_level),
        .full (full),
        .empty(empty)
    );
endmodule

// File: tb/tb_fir_output_decimator.sv
// tb_fir_output_decimator: scoreboard bench for the decimating FIR output stage (DECIM=1 and DECIM=4 instances)
module tb_fir_output_decimator;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    logic iv_a = 0, rdy_a = 0, clr_a = 0, ov_a, oval_a;
    logic iv_b = 0, rdy_b = 0, clr_b = 0, ov_b, oval_b;
    logic signed [31:0] id_a = 0, id_b = 0;
    logic signed [15:0] od_a, od_b;
    logic [2:0] lvl_a, lvl_b;
    logic [7:0] dc_a, dc_b;
    int tests = 0, fails = 0, max_lvl_b = 0, seen_b = 0;
    int q_a[$], q_b[$];
    fir_output_decimator #(.DECIM(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(iv_a), .in_data(id_a), .out_valid(oval_a), .out_ready(rdy_a),
        .out_data(od_a), .fifo_level(lvl_a), .overflow(ov_a), .clr_overflow(clr_a), .drop_count(dc_a));
    fir_output_decimator #(.DECIM(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_data(id_b), .out_valid(oval_b), .out_ready(rdy_b),
        .out_data(od_b), .fifo_level(lvl_b), .overflow(ov_b), .clr_overflow(clr_b), .drop_count(dc_b));
    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk)
        if (!reset && oval_a && rdy_a) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected: got %0d expected no output", od_a);
            end else chk("a_data", od_a, q_a.pop_front());
        end
    always @(negedge clk)
        if (!reset) begin
            if (int'(lvl_b) > max_lvl_b) max_lvl_b = int'(lvl_b);
            if (oval_b && rdy_b) begin
                seen_b++;
                if (q_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected: got %0d expected no output", od_b);
                end else chk("b_data", od_b, q_b.pop_front());
            end
        end
    logic signed [31:0] ins [4] = '{32'h00004000, 32'h3FFF8000, 32'hFFFFC000, 32'h00003FFF};
    int                 exps[4] = '{1, 32767, 0, 0};
    initial begin
        repeat (2) step;
        reset = 1'b0;
        chk("rst_out_valid", oval_a, 0);
        chk("rst_out_data", od_a, 0);
        chk("rst_level", lvl_a, 0);
        chk("rst_overflow", ov_a, 0);
        chk("rst_drop_count", dc_a, 0);
        chk("rst_b_out_valid", oval_b, 0);
        // DECIM=4 with input gaps: only k = 0, 4, 8 survive
        rdy_b = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) q_b.push_back(k);
            iv_b = 1'b1;
            id_b = k * 32768;
            step;
            if (k % 3 == 1) begin
                iv_b = 1'b0;
                step;
            end
        end
        iv_b = 1'b0;
        repeat (4) step;
        chk("b_drained", q_b.size(), 0);
        chk("b_outputs", seen_b, 3);
        chk("b_max_level", max_lvl_b, 1);
        // DECIM=1 rounding with two-cycle latency
        rdy_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(exps[i]);
            iv_a = 1'b1;
            id_a = ins[i];
            step;
            iv_a = 1'b0;
            chk("lat_n1", oval_a, 0);
            step;
            chk("lat_n2", oval_a, 1);
            step;
        end
        q_a.push_back(32767);
        q_a.push_back(-32768);
        iv_a = 1'b1;
        id_a = 32'h7FFFFFFF;
        step;
        id_a = 32'h80000000;
        step;
        iv_a = 1'b0;
        repeat (4) step;
        chk("sat_drained", q_a.size(), 0);
        // stalled sink: 7 samples into a 4-deep FIFO
        rdy_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) q_a.push_back(k);
            iv_a = 1'b1;
            id_a = k * 32768;
            step;
        end
        iv_a = 1'b0;
        repeat (2) step;
        chk("bp_level", lvl_a, 4);
        chk("bp_overflow", ov_a, 1);
        chk("bp_drop_count", dc_a, 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stable", od_a, 1);
            step;
        end
        rdy_a = 1'b1;
        repeat (6) step;
        chk("bp_drained", q_a.size(), 0);
        chk("bp_level_empty", lvl_a, 0);
        clr_a = 1'b1;
        step;
        clr_a = 1'b0;
        chk("clr_overflow", ov_a, 0);
        chk("clr_drop_count", dc_a, 0);
        // full FIFO with a pop in the same cycle as the push
        rdy_a = 1'b0;
        for (int k = 5; k <= 8; k++) begin
            q_a.push_back(k);
            iv_a = 1'b1;
            id_a = k * 32768;
            step;
        end
        iv_a = 1'b0;
        repeat (2) step;
        chk("full_level", lvl_a, 4);
        q_a.push_back(9);
        iv_a = 1'b1;
        id_a = 9 * 32768;
        step;
        iv_a = 1'b0;
        rdy_a = 1'b1;
        step;
        rdy_a = 1'b0;
        chk("pushpop_level", lvl_a, 4);
        chk("pushpop_overflow", ov_a, 0);
        chk("pushpop_drop_count", dc_a, 0);
        // clear in the same cycle as a drop
        iv_a = 1'b1;
        id_a = 10 * 32768;
        step;
        iv_a = 1'b0;
        clr_a = 1'b1;
        step;
        clr_a = 1'b0;
        chk("clrdrop_overflow", ov_a, 1);
        chk("clrdrop_drop_count", dc_a, 1);
        // asynchronous reset with 3 entries buffered
        rdy_a = 1'b1;
        step;
        rdy_a = 1'b0;
        chk("pre_rst_level", lvl_a, 3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", oval_a, 0);
        chk("async_rst_level", lvl_a, 0);
        chk("async_rst_overflow", ov_a, 0);
        chk("async_rst_drop_count", dc_a, 0);
        q_a.delete();
        step;
        reset = 1'b0;
        step;
        q_a.push_back(11);
        iv_a = 1'b1;
        id_a = 11 * 32768;
        step;
        iv_a = 1'b0;
        chk("post_rst_lat_n1", oval_a, 0);
        step;
        chk("post_rst_lat_n2", oval_a, 1);
        rdy_a = 1'b1;
        repeat (3) step;
        chk("post_rst_drained", q_a.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_output_decimator.md
Name: fir_output_decimator

Overview:
Output stage placed directly after the 17-tap FIR low-pass.
- Takes the 32-bit signed accumulator stream and keeps every DECIM-th sample.
- Rounds, shifts and saturates each kept sample to 16-bit signed.
- Buffers results in a small FIFO and hands them downstream over a valid/ready handshake.
- Raises a sticky overflow flag and counts drops when downstream stalls too long.

Parameters:
IN_W, 32, input sample width (signed two's complement)
OUT_W, 16, output sample width (signed)
SHIFT, 15, right-shift applied after rounding; 1 <= SHIFT <= IN_W-1
DECIM, 4, decimation factor; 1 = keep every sample
FIFO_DEPTH, 4, output buffer entries; power of two, >= 2

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  in_data carries a new filter sample this cycle
in_data  in  IN_W  signed filter accumulator value
out_valid  out  1  out_data holds a buffered sample
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
out_data  out  OUT_W  signed rounded/saturated sample at FIFO head
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
overflow  out  1  sticky: a kept sample was dropped
clr_overflow  in  1  one-cycle pulse clears overflow and drop_count
drop_count  out  8  dropped-sample count, saturates at 255

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is asynchronous, active-high.
- Reset values: out_valid=0, out_data=0, fifo_level=0, overflow=0, drop_count=0, phase counter=0, stage valid=0. FIFO pointers=0.
- Reset mid-operation discards all buffered and in-flight samples. No output handshake may complete in the cycle reset deasserts.
- Decimation phase counter:
  - Counts 0..DECIM-1 and advances only when in_valid=1, wrapping DECIM-1 -> 0.
  - A sample is kept when in_valid=1 and phase==0, so the first valid sample after reset is always kept.
  - With DECIM=1 every valid sample is kept.
  - Cycles with in_valid=0 leave the phase unchanged.
- Scaling, stage register (1 cycle):
  - Sign-extend to IN_W+1 bits, add 2^(SHIFT-1), then arithmetic shift right by SHIFT (round half toward +inf).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the result as stage data/valid.
- FIFO push: in the cycle after acceptance, stage valid pushes into the FIFO.
- Latency: sample kept at cycle N -> written to FIFO at end of N+1 -> out_valid=1 and out_data valid at N+2 (FIFO previously empty).
- FIFO behaviour:
  - Show-ahead: out_data = entry at read pointer; out_valid = (level != 0).
  - Pointers wrap modulo FIFO_DEPTH.
  - Level changes: +1 on push only, -1 on pop only, unchanged on push+pop.
- Full FIFO:
  - A push with pop in the same cycle is accepted; no drop.
  - A push without pop while level==FIFO_DEPTH is dropped: overflow<=1, drop_count increments (holds at 255).
- Empty FIFO: out_valid=0, out_data holds its last value, and out_ready is ignored.
- Status clear:
  - clr_overflow in the same cycle as a drop: the drop wins, so overflow=1 and drop_count=1.
  - clr_overflow alone: overflow=0, drop_count=0.
- out_data is stable while out_valid=1 and out_ready=0.
- No backpressure to the filter; the input side never stalls.

Decomposition:
- Package fir_out_pkg holds:
  - Width constants IN_W/OUT_W.
  - Typedefs sample_in_t (logic signed [31:0]) and sample_out_t (logic signed [15:0]).
  - Constants SAT_MAX=32767 and SAT_MIN=-32768.
  - Function round_sat(in, shift) implementing the scaling rule.
- One sub-module: sync_fifo (parameterised width/depth, show-ahead, push/pop/level/full/empty).
- Decimation, scaling stage and status logic live in the top.

Test Plan:
- DECIM=1, SHIFT=15: single valid samples 0x00004000, 0x3FFF8000, 0xFFFFC000, 0x00003FFF with out_ready=1 -> out_data 1, 32767, 0, 0, each appearing 2 cycles after input.
- Saturation: in_data 0x7FFFFFFF then 0x80000000 -> out_data 32767 then -32768.
- DECIM=4: 12 consecutive valid samples with in_data = 32768*k, k=0..11, and gaps of in_valid=0 inserted -> outputs exactly 0, 4, 8 (inputs k=0, 4, 8); fifo_level never exceeds 1.
- Backpressure: DECIM=1, out_ready=0, 7 valid samples -> fifo_level reaches 4, overflow=1, drop_count=3. Then out_ready=1 -> first 4 samples emitted in order, and out_data is stable while stalled.
- Full plus simultaneous pop: level=4, out_ready=1 while a stage push arrives -> no drop, level stays 4, overflow stays 0.
- Clear and reset:
  - clr_overflow pulse with no drop -> overflow=0, drop_count=0.
  - clr_overflow coincident with a drop -> overflow=1, drop_count=1.
  - Assert reset with 3 entries buffered -> out_valid=0 and fifo_level=0 immediately (asynchronous); the next kept sample appears 2 cycles after acceptance.
